pc_unit: RTL and testbench

Parametrised program-counter unit for the multicycle CPU. Holds the current instruction address, computes the next address from four sources (sequential, branch, register, jump) and updates only on a clock edge with PCWre high. Rejects misaligned targets and optionally carries a return-address stack for call/return. Sits between the control unit (PCWre, PCSrc, stack commands) and instruction memory (addressOut).

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_ras.sv | 84 ++++++++
 rtl/pc_unit.sv | 123 ++++++++++++
 tb/tb_pc_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared encodings and helpers for the program-counter unit.
package pc_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam int unsigned PC_INC = 32'd4;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer whose oldest entry is overwritten
// when a push arrives while the stack is full.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_cnt;

  logic          w_empty;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_replace;
  logic [PW-1:0] w_wr_idx;

  // Decode the stack action for this accepted write.
  always_comb begin
    w_empty   = (r_cnt == '0);
    w_full    = (r_cnt == FULL_CNT);
    w_do_push = i_en & i_push;
    w_do_pop  = i_en & i_pop & ~w_empty;
    w_replace = w_do_push & w_do_pop;
    if (w_replace) begin
      w_wr_idx = r_top;
    end else begin
      w_wr_idx = r_top + PW'(1);
    end
  end

  // Top pointer and occupancy; a full push wraps onto the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top <= '1;
      r_cnt <= '0;
    end else if (w_replace) begin
      r_top <= r_top;
      r_cnt <= r_cnt;
    end else if (w_do_push) begin
      r_top <= r_top + PW'(1);
      if (!w_full) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end else if (w_do_pop) begin
      r_top <= r_top - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_top <= r_top;
      r_cnt <= r_cnt;
    end
  end

  // Entry storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  assign o_top   = r_mem[r_top];
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/pc_unit.sv
// Program counter with four next-PC sources and misalignment rejection.
// Optional return-address stack built when PC_RAS_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] imm,
  input  logic [25:0]      jaddr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] addressOut,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misalign,
  output logic             ras_empty,
  output logic             ras_full
);

  logic [WIDTH-1:0] r_pc;
  logic             r_misalign;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_jump;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_target;
  logic             w_aligned;

  assign w_pc_plus4 = r_pc + WIDTH'(PC_INC);

  // Region bits above the 28-bit jump field come from the sequential address.
  generate
    if (WIDTH > 28) begin : g_jump_hi
      assign w_jump = {w_pc_plus4[WIDTH-1:28], jaddr, 2'b00};
    end else begin : g_jump_lo
      assign w_jump = {jaddr, 2'b00};
    end
  endgenerate

  // Next-PC source select.
  always_comb begin
    case (PCSrc)
      PC_SEQ:    w_sel = w_pc_plus4;
      PC_BRANCH: w_sel = w_pc_plus4 + (imm << 2);
      PC_REG:    w_sel = rs_data;
      PC_JUMP:   w_sel = w_jump;
      default:   w_sel = w_pc_plus4;
    endcase
  end

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic             w_accept;

  assign w_accept = PCWre & w_aligned;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (CLK),
    .rst_n   (RST),
    .i_en    (w_accept),
    .i_push  (ras_push),
    .i_pop   (ras_pop),
    .i_data  (w_pc_plus4),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full)
  );

  // A return overrides PCSrc only when the stack has something to return to.
  always_comb begin
    if (ras_pop && !w_ras_empty) begin
      w_target = w_ras_top;
    end else begin
      w_target = w_sel;
    end
  end

  assign ras_empty = w_ras_empty;
  assign ras_full  = w_ras_full;
`else
  logic w_unused_ras;
  assign w_unused_ras = ras_push ^ ras_pop;
  assign w_target     = w_sel;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
`endif

  assign w_aligned = is_word_aligned(w_target[1:0]);

  // PC register; a misaligned target is dropped and flagged for one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
    end else if (PCWre) begin
      if (w_aligned) begin
        r_pc <= w_target;
      end else begin
        r_pc <= r_pc;
      end
      r_misalign <= ~w_aligned;
    end else begin
      r_pc       <= r_pc;
      r_misalign <= 1'b0;
    end
  end

  assign addressOut = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign misalign   = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed cases then random traffic against a queue-based model.
module tb_pc_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0100;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] imm = 32'd0;
  logic [25:0] jaddr = 26'd0;
  logic [31:0] rs_data = 32'd0;
  logic        ras_push = 1'b0;
  logic        ras_pop = 1'b0;
  logic [31:0] addressOut;
  logic [31:0] pc_plus4;
  logic        misalign;
  logic        ras_empty;
  logic        ras_full;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PCWre(PCWre), .PCSrc(PCSrc), .imm(imm), .jaddr(jaddr),
    .rs_data(rs_data), .ras_push(ras_push), .ras_pop(ras_pop), .addressOut(addressOut),
    .pc_plus4(pc_plus4), .misalign(misalign), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic        emp;
    logic        ful;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue what the PC unit must show after the edge.
  task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] im,
                       input logic [25:0] ja, input logic [31:0] rs,
                       input logic pu, input logic po);
    exp_t        e;
    logic [31:0] p4;
    logic [31:0] tgt;
    @(negedge CLK);
    PCWre = we; PCSrc = src; imm = im; jaddr = ja; rs_data = rs;
    ras_push = pu; ras_pop = po;
    p4 = m_pc + 32'd4;
    case (src)
      2'd0:    tgt = p4;
      2'd1:    tgt = p4 + im * 32'd4;
      2'd2:    tgt = rs;
      default: tgt = (p4 & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
    endcase
    if (RAS_EN && po && m_stack.size() > 0) tgt = m_stack[m_stack.size()-1];
    e.mis = 1'b0;
    if (we) begin
      if (tgt % 32'd4 != 32'd0) begin
        e.mis = 1'b1;
      end else begin
        if (RAS_EN && pu && po && m_stack.size() > 0) begin
          m_stack[m_stack.size()-1] = p4;
        end else begin
          if (RAS_EN && po && m_stack.size() > 0) m_stack.delete(m_stack.size()-1);
          if (RAS_EN && pu) begin
            if (m_stack.size() == DEPTH) m_stack.delete(0);
            m_stack.push_back(p4);
          end
        end
        m_pc = tgt;
      end
    end
    e.pc  = m_pc;
    e.emp = (m_stack.size() == 0);
    e.ful = (m_stack.size() == DEPTH);
    sb_q.push_back(e);
  endtask

  always @(posedge CLK) begin
    #1;
    if (RST && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("addressOut", addressOut, mon_e.pc);
      chk("pc_plus4", pc_plus4, mon_e.pc + 32'd4);
      chk("misalign", 32'(misalign), 32'(mon_e.mis));
      chk("ras_empty", 32'(ras_empty), 32'(mon_e.emp));
      chk("ras_full", 32'(ras_full), 32'(mon_e.ful));
    end
  end

  task automatic check_reset_state();
    chk("rst_addressOut", addressOut, RV);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_ras_empty", 32'(ras_empty), 32'd1);
    chk("rst_ras_full", 32'(ras_full), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs;
    m_pc = RV;
    #2 RST = 1'b0;
    #1 check_reset_state();
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 3; i++) drive(1'b1, 2'd0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h200, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h200, 1'b0, 1'b0);
    drive(1'b0, 2'd1, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h302, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h1000_0040, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 32'd0, 26'h10, 32'd0, 1'b0, 1'b0);

    // Call depth beyond capacity, then unwind past empty.
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h10 * i, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h500, 1'b0, 1'b1);

    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h80, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h50, 1'b1, 1'b0);
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h600, 1'b1, 1'b1);
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h600, 1'b0, 1'b1);
    drive(1'b1, 2'd2, 32'd0, 26'd0, 32'h600, 1'b1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      rs = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rs[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            32'($urandom_range(0, 64)) - 32'd32, 26'($urandom), rs,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      if (n == 150) begin
        @(negedge CLK);
        PCWre = 1'b1;
        RST = 1'b0;
        #1 check_reset_state();
        m_pc = RV;
        m_stack.delete();
        PCWre = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
      end
    end
    drive(1'b0, 2'd0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #2 chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
